prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the program word width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; memory depth SHALL be 2^ADDR_W words.
REQ-003 Parameter DEBOUNCE, default 4, range 1..255, SHALL set the number of consecutive stable cycles needed to accept a button edge.
REQ-004 clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 prog_mode  input  1  1 = program mode, 0 = run mode.
REQ-007 prog_btn_n  input  1  raw active-low program push button, asynchronous to clock.
REQ-008 prog_data  input  DATA_W  word taken from the slide switches.
REQ-009 verify  input  1  1 = an accepted press compares the stored word instead of writing it.
REQ-010 rd_addr  input  ADDR_W  CPU fetch address.
REQ-011 rd_data  output  DATA_W  registered fetch data.
REQ-012 wr_addr  output  ADDR_W  current load pointer.
REQ-013 prog_count  output  ADDR_W+1  number of presses accepted since the pointer was last cleared.
REQ-014 full  output  1  all 2^ADDR_W locations have been loaded or checked.
REQ-015 mismatch  output  1  sticky verify-failure flag.
REQ-016 busy  output  1  high in every FSM state except IDLE.

Function
REQ-017 prog_btn_n SHALL pass through a 2-flop synchronizer; only the synchronized signal (btn_s) SHALL be used.
REQ-018 FSM states SHALL be IDLE, DEB_PRESS, ACT, DEB_REL.
REQ-019 IDLE -> DEB_PRESS when btn_s=0 and prog_mode=1; the debounce counter SHALL be cleared on entry.
REQ-020 DEB_PRESS SHALL count consecutive btn_s=0 cycles; a btn_s=1 cycle SHALL return the FSM to IDLE with no action; when the count reaches DEBOUNCE -> ACT.
REQ-021 ACT SHALL last exactly one cycle and then go to DEB_REL.
- verify=0 and full=0: mem[wr_addr] <= prog_data.
- verify=1 and full=0: mismatch <= 1 if mem[wr_addr] != prog_data; memory unchanged.
- full=0: wr_addr increments and prog_count increments.
REQ-022 In ACT with full=1, the press SHALL be ignored: no write, no compare, wr_addr and prog_count unchanged.
REQ-023 DEB_REL SHALL return to IDLE after DEBOUNCE consecutive btn_s=1 cycles; any btn_s=0 cycle SHALL restart the count.
REQ-024 Each physical press SHALL cause at most one ACT.
REQ-025 When wr_addr wraps from 2^ADDR_W-1 to 0, full SHALL be set.
- full SHALL remain set until reset or until program mode is re-entered.
- prog_count SHALL then read 2^ADDR_W.
REQ-026 A 0->1 transition of prog_mode SHALL, in the following cycle, clear wr_addr, prog_count, full and mismatch; memory SHALL be preserved.
REQ-027 While prog_mode=0, the FSM SHALL be forced to IDLE and the button SHALL be ignored.
- A prog_mode 1->0 change in any state SHALL abort the operation; any pending ACT SHALL be dropped.
REQ-028 rd_data SHALL equal mem[rd_addr] sampled one cycle earlier, in both modes.
- A same-cycle write to rd_addr SHALL return the old data (read-before-write).
REQ-029 verify may change at any time; the value sampled in the ACT cycle SHALL decide the action.

Reset
REQ-030 On reset, in the same clock edge:
- FSM to IDLE; debounce counter, wr_addr, prog_count, full, mismatch and rd_data SHALL be 0.
- Synchronizer flops SHALL be set to 1 (button released).
REQ-031 Memory contents SHALL NOT be affected by reset.
REQ-032 reset SHALL take priority over every other event, including an ACT in the same cycle.

Verification
REQ-033 Scenario 1: prog_mode=1; press with prog_data 0x81, 0x10, 0x06, each held 10 cycles and released 10 cycles -> mem[0..2] = 81,10,06; wr_addr=3; prog_count=3; rd_addr=1 gives rd_data=0x10 one cycle later.
REQ-034 Scenario 2: DEBOUNCE=4; button low 3 cycles then high -> no write, wr_addr unchanged, busy back to 0.
REQ-035 Scenario 3: 32 presses (ADDR_W=5) -> full=1, wr_addr=0, prog_count=32; a 33rd press with 0xFE -> mem[0] unchanged.
REQ-036 Scenario 4: after Scenario 1, toggle prog_mode 0->1, set verify=1, press 0x81 then 0x11 -> mismatch=0 after the first press, then 1 after the second and sticky; memory unchanged.
REQ-037 Scenario 5: assert reset during DEB_PRESS -> FSM IDLE and all outputs 0 next cycle; a held button SHALL be re-debounced from zero after reset.
REQ-038 Scenario 6: prog_mode 1->0 during DEB_PRESS -> no write occurs; in run mode, presses have no effect.

Source files
------------

// File: rtl/prog_loader.sv
// Switch-panel program loader: debounces a push button and writes (or verifies)
// slide-switch words into a small program memory that the CPU fetches from.
module prog_loader #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int DEBOUNCE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              prog_mode,
  input  logic              prog_btn_n,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              verify,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   prog_count,
  output logic              full,
  output logic              mismatch,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE - 1);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, ACT, DEB_REL} state_e;

  state_e              state_q, state_d;
  logic [7:0]          debCnt_q, debCnt_d;
  logic                syncA_q, btnS_q;
  logic                modePrev_q;
  logic [ADDR_W-1:0]   wrAddr_q;
  logic [ADDR_W:0]     progCount_q;
  logic                full_q, mismatch_q;
  logic [DATA_W-1:0]   rdData_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                doAct, modeRise;

  // Synchronizer idles at 1 so reset looks like a released button.
  always_ff @(posedge clock) begin
    if (reset) begin
      syncA_q    <= 1'b1;
      btnS_q     <= 1'b1;
      modePrev_q <= 1'b0;
    end else begin
      syncA_q    <= prog_btn_n;
      btnS_q     <= syncA_q;
      modePrev_q <= prog_mode;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      debCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      debCnt_q <= debCnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    debCnt_d = debCnt_q;
    if (!prog_mode) begin
      state_d  = IDLE;
      debCnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!btnS_q) begin
            state_d  = DEB_PRESS;
            debCnt_d = '0;
          end
        end
        DEB_PRESS: begin
          if (btnS_q)                   state_d  = IDLE;
          else if (debCnt_q == DEB_LAST) state_d  = ACT;
          else                          debCnt_d = debCnt_q + 8'd1;
        end
        ACT: begin
          state_d  = DEB_REL;
          debCnt_d = '0;
        end
        DEB_REL: begin
          // Any bounce low during release restarts the quiet-time count.
          if (!btnS_q)                   debCnt_d = '0;
          else if (debCnt_q == DEB_LAST) state_d  = IDLE;
          else                           debCnt_d = debCnt_q + 8'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign doAct    = (state_q == ACT) && prog_mode && !full_q;
  assign modeRise = prog_mode && !modePrev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wrAddr_q    <= '0;
      progCount_q <= '0;
      full_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      rdData_q    <= '0;
    end else begin
      rdData_q <= mem[rd_addr];
      if (modeRise) begin
        wrAddr_q    <= '0;
        progCount_q <= '0;
        full_q      <= 1'b0;
        mismatch_q  <= 1'b0;
      end else if (doAct) begin
        if (verify && (mem[wrAddr_q] != prog_data)) mismatch_q <= 1'b1;
        wrAddr_q    <= wrAddr_q + 1'b1;
        progCount_q <= progCount_q + 1'b1;
        if (wrAddr_q == {ADDR_W{1'b1}}) full_q <= 1'b1;
      end
    end
  end

  // Memory has no reset so a loaded program survives a CPU reset.
  always_ff @(posedge clock) begin
    if (doAct && !verify && !reset) mem[wrAddr_q] <= prog_data;
  end

  assign rd_data    = rdData_q;
  assign wr_addr    = wrAddr_q;
  assign prog_count = progCount_q;
  assign full       = full_q;
  assign mismatch   = mismatch_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (DATA_W=8, ADDR_W=5, DEBOUNCE=4).
module tb_prog_loader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       prog_mode = 1'b0;
  logic       prog_btn_n = 1'b1;
  logic [7:0] prog_data = '0;
  logic       verify = 1'b0;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic [4:0] wr_addr;
  logic [5:0] prog_count;
  logic       full, mismatch, busy;

  int nChecks = 0;
  int nFails  = 0;

  prog_loader #(.DATA_W(8), .ADDR_W(5), .DEBOUNCE(4)) dut (
    .clock(clock), .reset(reset), .prog_mode(prog_mode), .prog_btn_n(prog_btn_n),
    .prog_data(prog_data), .verify(verify), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_addr(wr_addr), .prog_count(prog_count), .full(full), .mismatch(mismatch),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Full press: 10 cycles held, 10 cycles released, ends on a negedge.
  task automatic pressButton(input logic [7:0] data);
    @(negedge clock);
    prog_data  = data;
    prog_btn_n = 1'b0;
    repeat (10) @(negedge clock);
    prog_btn_n = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    nChecks++; if ({busy, full, mismatch} !== 3'b000) begin nFails++; $display("[TB] FAIL reset_flags got %b want 000", {busy, full, mismatch}); end
    nChecks++; if (wr_addr !== 5'd0 || prog_count !== 6'd0) begin nFails++; $display("[TB] FAIL reset_ptr got %0d/%0d want 0/0", wr_addr, prog_count); end
    nChecks++; if (rd_data !== 8'h00) begin nFails++; $display("[TB] FAIL reset_rd got %h want 00", rd_data); end
    reset = 1'b0;
  endtask

  task automatic test_load;
    @(negedge clock);
    prog_mode = 1'b1;
    repeat (2) @(negedge clock);
    pressButton(8'h81);
    pressButton(8'h10);
    pressButton(8'h06);
    nChecks++; if (wr_addr !== 5'd3) begin nFails++; $display("[TB] FAIL load_wr_addr got %0d want 3", wr_addr); end
    nChecks++; if (prog_count !== 6'd3) begin nFails++; $display("[TB] FAIL load_count got %0d want 3", prog_count); end
    rd_addr = 5'd1; @(negedge clock);
    nChecks++; if (rd_data !== 8'h10) begin nFails++; $display("[TB] FAIL load_rd1 got %h want 10", rd_data); end
    rd_addr = 5'd0; @(negedge clock);
    nChecks++; if (rd_data !== 8'h81) begin nFails++; $display("[TB] FAIL load_rd0 got %h want 81", rd_data); end
    rd_addr = 5'd2; @(negedge clock);
    nChecks++; if (rd_data !== 8'h06) begin nFails++; $display("[TB] FAIL load_rd2 got %h want 06", rd_data); end
  endtask

  task automatic test_glitch;
    prog_data  = 8'hAA;
    prog_btn_n = 1'b0;
    repeat (3) @(negedge clock);
    prog_btn_n = 1'b1;
    nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL glitch_busy_during got %b want 1", busy); end
    repeat (10) @(negedge clock);
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL glitch_busy_after got %b want 0", busy); end
    nChecks++; if (wr_addr !== 5'd3) begin nFails++; $display("[TB] FAIL glitch_wr_addr got %0d want 3", wr_addr); end
    rd_addr = 5'd2; @(negedge clock);
    nChecks++; if (rd_data !== 8'h06) begin nFails++; $display("[TB] FAIL glitch_mem got %h want 06", rd_data); end
  endtask

  task automatic test_verify;
    prog_mode = 1'b0; repeat (2) @(negedge clock);
    prog_mode = 1'b1; repeat (2) @(negedge clock);
    nChecks++; if (wr_addr !== 5'd0 || prog_count !== 6'd0) begin nFails++; $display("[TB] FAIL reenter_ptr got %0d/%0d want 0/0", wr_addr, prog_count); end
    verify = 1'b1;
    pressButton(8'h81);
    nChecks++; if (mismatch !== 1'b0) begin nFails++; $display("[TB] FAIL verify_match got %b want 0", mismatch); end
    nChecks++; if (wr_addr !== 5'd1) begin nFails++; $display("[TB] FAIL verify_wr_addr got %0d want 1", wr_addr); end
    pressButton(8'h11);
    nChecks++; if (mismatch !== 1'b1) begin nFails++; $display("[TB] FAIL verify_miss got %b want 1", mismatch); end
    pressButton(8'h06);
    nChecks++; if (mismatch !== 1'b1) begin nFails++; $display("[TB] FAIL verify_sticky got %b want 1", mismatch); end
    rd_addr = 5'd1; @(negedge clock);
    nChecks++; if (rd_data !== 8'h10) begin nFails++; $display("[TB] FAIL verify_mem1 got %h want 10", rd_data); end
    verify = 1'b0;
  endtask

  task automatic test_mode_abort;
    prog_mode = 1'b0; repeat (2) @(negedge clock);
    pressButton(8'h55);
    nChecks++; if (wr_addr !== 5'd3 || busy !== 1'b0) begin nFails++; $display("[TB] FAIL run_press got wr=%0d busy=%b want 3/0", wr_addr, busy); end
    nChecks++; if (mismatch !== 1'b1) begin nFails++; $display("[TB] FAIL run_mismatch got %b want 1", mismatch); end
    prog_mode = 1'b1; repeat (2) @(negedge clock);
    nChecks++; if (mismatch !== 1'b0 || wr_addr !== 5'd0) begin nFails++; $display("[TB] FAIL reenter_clear got mm=%b wr=%0d want 0/0", mismatch, wr_addr); end
    prog_data  = 8'h99;
    prog_btn_n = 1'b0;
    repeat (5) @(negedge clock);
    nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL abort_busy_before got %b want 1", busy); end
    prog_mode = 1'b0;
    repeat (10) @(negedge clock);
    prog_btn_n = 1'b1;
    repeat (10) @(negedge clock);
    nChecks++; if (busy !== 1'b0 || wr_addr !== 5'd0) begin nFails++; $display("[TB] FAIL abort_state got busy=%b wr=%0d want 0/0", busy, wr_addr); end
    rd_addr = 5'd0; @(negedge clock);
    nChecks++; if (rd_data !== 8'h81) begin nFails++; $display("[TB] FAIL abort_mem0 got %h want 81", rd_data); end
  endtask

  task automatic test_reset_mid_press;
    prog_mode = 1'b1; repeat (2) @(negedge clock);
    prog_data  = 8'h3C;
    prog_btn_n = 1'b0;
    repeat (5) @(negedge clock);
    nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL rstmid_busy_before got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clock);
    nChecks++; if ({busy, full, mismatch} !== 3'b000 || wr_addr !== 5'd0 || prog_count !== 6'd0 || rd_data !== 8'h00)
      begin nFails++; $display("[TB] FAIL rstmid_outputs got busy=%b wr=%0d cnt=%0d rd=%h", busy, wr_addr, prog_count, rd_data); end
    reset = 1'b0;
    repeat (6) @(negedge clock);
    nChecks++; if (wr_addr !== 5'd0) begin nFails++; $display("[TB] FAIL rstmid_redebounce_early got %0d want 0", wr_addr); end
    repeat (2) @(negedge clock);
    nChecks++; if (wr_addr !== 5'd1) begin nFails++; $display("[TB] FAIL rstmid_redebounce_done got %0d want 1", wr_addr); end
    prog_btn_n = 1'b1;
    repeat (10) @(negedge clock);
    rd_addr = 5'd0; @(negedge clock);
    nChecks++; if (rd_data !== 8'h3C) begin nFails++; $display("[TB] FAIL rstmid_mem0 got %h want 3c", rd_data); end
  endtask

  task automatic test_full;
    prog_mode = 1'b0; repeat (2) @(negedge clock);
    prog_mode = 1'b1; repeat (2) @(negedge clock);
    for (int i = 0; i < 31; i++) pressButton(8'h40 + 8'(i));
    nChecks++; if (full !== 1'b0 || wr_addr !== 5'd31 || prog_count !== 6'd31) begin nFails++; $display("[TB] FAIL full_at31 got f=%b wr=%0d cnt=%0d want 0/31/31", full, wr_addr, prog_count); end
    pressButton(8'h5F);
    nChecks++; if (full !== 1'b1 || wr_addr !== 5'd0 || prog_count !== 6'd32) begin nFails++; $display("[TB] FAIL full_at32 got f=%b wr=%0d cnt=%0d want 1/0/32", full, wr_addr, prog_count); end
    pressButton(8'hFE);
    nChecks++; if (wr_addr !== 5'd0 || prog_count !== 6'd32) begin nFails++; $display("[TB] FAIL full_ignore got wr=%0d cnt=%0d want 0/32", wr_addr, prog_count); end
    rd_addr = 5'd0; @(negedge clock);
    nChecks++; if (rd_data !== 8'h40) begin nFails++; $display("[TB] FAIL full_mem0 got %h want 40", rd_data); end
    rd_addr = 5'd31; @(negedge clock);
    nChecks++; if (rd_data !== 8'h5F) begin nFails++; $display("[TB] FAIL full_mem31 got %h want 5f", rd_data); end
    prog_mode = 1'b0; repeat (2) @(negedge clock);
    prog_mode = 1'b1; repeat (2) @(negedge clock);
    nChecks++; if (full !== 1'b0 || prog_count !== 6'd0) begin nFails++; $display("[TB] FAIL full_clear got f=%b cnt=%0d want 0/0", full, prog_count); end
    rd_addr = 5'd5; @(negedge clock);
    nChecks++; if (rd_data !== 8'h45) begin nFails++; $display("[TB] FAIL full_mem5_kept got %h want 45", rd_data); end
  endtask

  initial begin
    test_reset;
    test_load;
    test_glitch;
    test_verify;
    test_mode_abort;
    test_reset_mid_press;
    test_full;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end

endmodule
